mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: decodes CPU byte-addressed loads/stores onto ROM, RAM,
// keyboard and display ports, one transaction at a time, with fixed read latencies.
module mem_bus_ctrl #(
  parameter int ROM_AW  = 12,
  parameter int RAM_AW  = 6,
  parameter int DISP_AW = 16,
  parameter int ROM_LAT = 1,
  parameter int RAM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic               req_write,
  input  logic [2:0]         req_size,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic               rom_en,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [31:0]        rom_rdata,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,
  output logic               kb_en,
  output logic [7:0]         kb_addr,
  input  logic [31:0]        kb_rdata,
  output logic               disp_we,
  output logic [3:0]         disp_be,
  output logic [DISP_AW-1:0] disp_addr,
  output logic [31:0]        disp_wdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {DEV_ROM, DEV_RAM, DEV_KB, DEV_DISP} dev_t;

  state_t     state;
  dev_t       dev_q;
  logic       write_q;
  logic [2:0] size_q;
  logic [1:0] addr_lo_q;
  logic [3:0] lat_q;
  logic [3:0] cnt;

  // Request decode, evaluated on the raw request so accept can act in one cycle
  dev_t        dev;
  logic        is_word;
  logic        is_half;
  logic        req_fault;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [3:0]  lat_sel;

  always_comb begin
    dev       = dev_t'(req_addr[29:28]);
    is_word   = req_size[1];
    is_half   = !req_size[1] && req_size[0];
    req_fault = (is_word && (req_addr[1:0] != 2'b00))
             || (is_half && req_addr[0])
             || (req_addr[31:30] != 2'b00)
             || (req_write && ((dev == DEV_ROM) || (dev == DEV_KB)))
             || (!req_write && (dev == DEV_DISP));
    if (is_word) begin
      be   = 4'b1111;
      wrep = req_wdata;
    end else if (is_half) begin
      be   = req_addr[1] ? 4'b1100 : 4'b0011;
      wrep = {2{req_wdata[15:0]}};
    end else begin
      be   = 4'b0001 << req_addr[1:0];
      wrep = {4{req_wdata[7:0]}};
    end
    case (dev)
      DEV_ROM: lat_sel = 4'(ROM_LAT);
      DEV_RAM: lat_sel = 4'(RAM_LAT);
      default: lat_sel = 4'd1;
    endcase
  end

  // Load result formatting from whichever device port is being read
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic        sext;
  logic [31:0] load_res;

  always_comb begin
    case (dev_q)
      DEV_ROM: rd_word = rom_rdata;
      DEV_RAM: rd_word = ram_rdata;
      default: rd_word = kb_rdata;
    endcase
    rd_shift = rd_word >> {addr_lo_q, 3'b000};
    rd_half  = addr_lo_q[1] ? rd_word[31:16] : rd_word[15:0];
    sext     = !size_q[2];
    if ((dev_q == DEV_KB) || size_q[1])
      load_res = rd_word;
    else if (size_q[0])
      load_res = {{16{sext & rd_half[15]}}, rd_half};
    else
      load_res = {{24{sext & rd_shift[7]}}, rd_shift[7:0]};
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      kb_en      <= 1'b0;
      kb_addr    <= '0;
      disp_we    <= 1'b0;
      disp_be    <= '0;
      disp_addr  <= '0;
      disp_wdata <= '0;
      dev_q      <= DEV_ROM;
      write_q    <= 1'b0;
      size_q     <= '0;
      addr_lo_q  <= '0;
      lat_q      <= '0;
      cnt        <= '0;
    end else begin
      // Strobes and the response pulse last one cycle unless re-asserted below
      rom_en     <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      kb_en      <= 1'b0;
      disp_we    <= 1'b0;
      disp_be    <= '0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            dev_q     <= dev;
            write_q   <= req_write;
            size_q    <= req_size;
            addr_lo_q <= req_addr[1:0];
            lat_q     <= lat_sel;
            if (req_fault) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              state <= ISSUE;
              case (dev)
                DEV_ROM: begin
                  rom_en   <= 1'b1;
                  rom_addr <= req_addr[ROM_AW+1:2];
                end
                DEV_RAM: begin
                  ram_en    <= 1'b1;
                  ram_addr  <= req_addr[RAM_AW+1:2];
                  ram_we    <= req_write ? be : 4'b0000;
                  ram_wdata <= wrep;
                end
                DEV_KB: begin
                  kb_en   <= 1'b1;
                  kb_addr <= req_addr[7:0];
                end
                default: begin
                  disp_we    <= 1'b1;
                  disp_be    <= be;
                  disp_addr  <= req_addr[DISP_AW+1:2];
                  disp_wdata <= wrep;
                end
              endcase
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            cnt   <= 4'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == lat_q) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_res;
            state      <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: byte-level reference memory, fixed-latency
// device models, directed cases plus randomized load/store traffic.
module tb_mem_bus_ctrl;
  localparam int ROM_AW  = 12;
  localparam int RAM_AW  = 6;
  localparam int DISP_AW = 16;
  localparam int ROM_LAT = 4;
  localparam int RAM_LAT = 2;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               req_write;
  logic [2:0]         req_size;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  logic               rom_en;
  logic [ROM_AW-1:0]  rom_addr;
  logic [31:0]        rom_rdata;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [RAM_AW-1:0]  ram_addr;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;
  logic               kb_en;
  logic [7:0]         kb_addr;
  logic [31:0]        kb_rdata;
  logic               disp_we;
  logic [3:0]         disp_be;
  logic [DISP_AW-1:0] disp_addr;
  logic [31:0]        disp_wdata;

  mem_bus_ctrl #(
    .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .DISP_AW(DISP_AW),
    .ROM_LAT(ROM_LAT), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .kb_en(kb_en), .kb_addr(kb_addr), .kb_rdata(kb_rdata),
    .disp_we(disp_we), .disp_be(disp_be), .disp_addr(disp_addr), .disp_wdata(disp_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    int          lat;
    logic        err;
    logic [31:0] rd;
    bit          chk_rd;
  } resp_t;

  typedef struct {
    int          cyc;
    int          dev;
    logic [31:0] addr;
    logic        w;
    logic [3:0]  be;
    logic [31:0] wd;
  } strb_t;

  resp_t rq[$];
  strb_t sq[$];

  logic [31:0] init_words [64];
  logic [7:0]  ref_mem    [256];
  logic [31:0] dev_ram    [64];
  bit          dev_load = 1'b1;

  function automatic logic [31:0] rom_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] kb_word(input logic [7:0] a);
    return 32'h00000131 + {24'h0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Device side: data is only valid in the cycle exactly LAT after the strobe
  logic        rom_v [16];
  logic [31:0] rom_a [16];
  logic        ram_v [16];
  logic [31:0] ram_a [16];
  logic        kb_v;
  logic [7:0]  kb_a;

  always @(negedge clk) begin
    if (dev_load)
      for (int i = 0; i < 64; i++) dev_ram[i] <= init_words[i];
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rom_v[i] <= 1'b0; rom_a[i] <= '0; ram_v[i] <= 1'b0; ram_a[i] <= '0;
      end
      kb_v <= 1'b0; kb_a <= '0;
      rom_rdata <= '0; ram_rdata <= '0; kb_rdata <= '0;
    end else begin
      for (int i = 1; i < 16; i++) begin
        rom_v[i] <= rom_v[i-1]; rom_a[i] <= rom_a[i-1];
        ram_v[i] <= ram_v[i-1]; ram_a[i] <= ram_a[i-1];
      end
      rom_v[0] <= rom_en;
      rom_a[0] <= 32'(rom_addr);
      ram_v[0] <= ram_en && (ram_we == 4'b0000);
      ram_a[0] <= 32'(ram_addr);
      kb_v     <= kb_en;
      kb_a     <= kb_addr;
      rom_rdata <= rom_v[ROM_LAT-1] ? rom_word(rom_a[ROM_LAT-1]) : $urandom();
      ram_rdata <= ram_v[RAM_LAT-1] ? dev_ram[ram_a[RAM_LAT-1][5:0]] : $urandom();
      kb_rdata  <= kb_v ? kb_word(kb_a) : $urandom();
      if (ram_en && (ram_we != 4'b0000))
        for (int k = 0; k < 4; k++)
          if (ram_we[k]) dev_ram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  // Monitor: strobes and responses are checked against the queued expectations
  always @(negedge clk) begin : mon
    resp_t e;
    strb_t s;
    int    n;
    if (!rst) begin
      n = int'(rom_en) + int'(ram_en) + int'(kb_en) + int'(disp_we);
      if (n > 0) begin
        chk("strobe_count", n, 1);
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got rom=%b ram=%b kb=%b disp=%b required none",
                   rom_en, ram_en, kb_en, disp_we);
        end else begin
          s = sq.pop_front();
          chk("strobe_delay", cyc - s.cyc, 1);
          case (s.dev)
            0: begin
              chk("rom_en", rom_en, 1);
              chk("rom_addr", 32'(rom_addr), s.addr);
            end
            1: begin
              chk("ram_en", ram_en, 1);
              chk("ram_addr", 32'(ram_addr), s.addr);
              chk("ram_we", ram_we, s.w ? s.be : 4'b0000);
              if (s.w) chk("ram_wdata", ram_wdata, s.wd);
            end
            2: begin
              chk("kb_en", kb_en, 1);
              chk("kb_addr", kb_addr, s.addr);
            end
            default: begin
              chk("disp_we", disp_we, 1);
              chk("disp_be", disp_be, s.be);
              chk("disp_addr", 32'(disp_addr), s.addr);
              chk("disp_wdata", disp_wdata, s.wd);
            end
          endcase
        end
      end else begin
        chk("idle_lanes", {ram_we, disp_be}, 0);
      end
      if (resp_valid) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h required no response", resp_rdata);
        end else begin
          e = rq.pop_front();
          chk("resp_latency", cyc - e.acc, e.lat);
          chk("resp_err", resp_err, e.err);
          if (e.chk_rd) chk("resp_rdata", resp_rdata, e.rd);
        end
      end
    end
  end

  // Drives one request, computes its expected effect from byte-level rules, queues it
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input bit dir, input logic e_err,
                       input logic [31:0] e_rd, input int e_lat);
    int          nb, region, waited, lat;
    logic        err;
    logic [31:0] rd, wrep, daddr, ba;
    logic [3:0]  be;
    logic [7:0]  b;
    resp_t       e;
    strb_t       s;
    req_addr = a; req_write = w; req_size = sz; req_wdata = wd; req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready got %b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    nb     = sz[1] ? 4 : (sz[0] ? 2 : 1);
    region = int'(a[31:28]);
    err    = ((int'(a[1:0]) % nb) != 0) || (region > 3)
          || (w && (region == 0 || region == 2)) || (!w && region == 3);
    rd = '0;
    if (!err && !w) begin
      if (region == 2) rd = kb_word(a[7:0]);
      else begin
        for (int i = 0; i < nb; i++) begin
          ba = a + 32'(i);
          if (region == 0) b = 8'(rom_word({20'b0, ba[13:2]}) >> (8 * ba[1:0]));
          else             b = ref_mem[ba[7:0]];
          rd = rd | (32'(b) << (8 * i));
        end
        if (!sz[2] && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFFFFFF << (8 * nb));
      end
    end
    be = '0;
    for (int i = 0; i < nb; i++) be[int'(a[1:0]) + i] = 1'b1;
    for (int k = 0; k < 4; k++) wrep[8*k +: 8] = wd[8*(k % nb) +: 8];
    case (region)
      0:       daddr = (a >> 2) & 32'h0FFF;
      1:       daddr = (a >> 2) & 32'h003F;
      2:       daddr = a & 32'h00FF;
      default: daddr = (a >> 2) & 32'hFFFF;
    endcase
    lat = err ? 1 : (w ? 2 : (region == 0 ? ROM_LAT + 2 : (region == 1 ? RAM_LAT + 2 : 3)));
    if (w && !err && region == 1)
      for (int i = 0; i < nb; i++) begin
        ba = a + 32'(i);
        ref_mem[ba[7:0]] = wd[8*i +: 8];
      end
    e.acc    = cyc;
    e.lat    = dir ? e_lat : lat;
    e.err    = dir ? e_err : err;
    e.rd     = dir ? e_rd : rd;
    e.chk_rd = e.err || !w;
    rq.push_back(e);
    if (!err) begin
      s.cyc = cyc; s.dev = region; s.addr = daddr; s.w = w; s.be = be; s.wd = wrep;
      sq.push_back(s);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((rq.size() != 0 || sq.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_pending", rq.size() + sq.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] ra, wd;
    logic [2:0]  sz;
    logic        w;
    int          r, region, nb, acc;
    strb_t       s;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      init_words[i] = $urandom();
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = init_words[i][8*k +: 8];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dev_load = 1'b0;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp", {resp_valid, resp_err}, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_strobes", {rom_en, ram_en, kb_en, disp_we, ram_we, disp_be}, 0);
    chk("reset_addrs", {rom_addr, ram_addr, kb_addr}, 0);
    chk("reset_disp", {disp_addr, 16'h0} | 32'(disp_wdata != 0), 0);

    issue(32'h10000004, 1'b1, 3'b010, 32'hDEADBEEF, 1, 1'b0, 32'h0, 2);
    issue(32'h10000007, 1'b0, 3'b000, 32'h0, 1, 1'b0, 32'hFFFFFFDE, 4);
    issue(32'h10000002, 1'b1, 3'b001, 32'h0000ABCD, 1, 1'b0, 32'h0, 2);
    issue(32'h10000002, 1'b0, 3'b001, 32'h0, 1, 1'b0, 32'hFFFFABCD, 4);
    issue(32'h10000002, 1'b0, 3'b101, 32'h0, 1, 1'b0, 32'h0000ABCD, 4);
    issue(32'h10000002, 1'b0, 3'b010, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(32'h00000000, 1'b1, 3'b010, 32'h12345678, 1, 1'b1, 32'h0, 1);
    issue(32'h40000000, 1'b0, 3'b010, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(32'h20000010, 1'b0, 3'b000, 32'h0, 1, 1'b0, 32'h00000141, 3);
    issue(32'h10000001, 1'b0, 3'b001, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(32'h30000005, 1'b1, 3'b000, 32'h00000077, 0, 1'b0, 32'h0, 0);
    issue(32'h30000000, 1'b0, 3'b010, 32'h0, 1, 1'b1, 32'h0, 1);
    issue(32'h00000010, 1'b0, 3'b010, 32'h0, 0, 1'b0, 32'h0, 0);
    drain();

    // Reset during WAIT of a ROM read: no response, ready right after, then normal traffic
    req_addr = 32'h00000100; req_write = 1'b0; req_size = 3'b010; req_valid = 1'b1;
    chk("midrst_ready_before", req_ready, 1);
    acc = cyc;
    s.cyc = acc; s.dev = 0; s.addr = 32'h40; s.w = 1'b0; s.be = 4'b1111; s.wd = '0;
    sq.push_back(s);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_strobes", {rom_en, ram_en, kb_en, disp_we}, 0);
    repeat (8) @(negedge clk);
    issue(32'h00000104, 1'b0, 3'b010, 32'h0, 1, 1'b0, rom_word(32'h41), ROM_LAT + 2);
    drain();

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      region = (r < 1) ? 0 : (r < 5) ? 1 : (r < 6) ? 2 : (r < 8) ? 3 : $urandom_range(4, 15);
      sz = 3'($urandom_range(0, 7));
      nb = sz[1] ? 4 : (sz[0] ? 2 : 1);
      ra = $urandom();
      ra[31:28] = 4'(region);
      if ($urandom_range(0, 3) != 0) ra = ra & ~32'(nb - 1);
      if (region == 0 || region == 2) w = ($urandom_range(0, 7) == 0);
      else if (region == 3)           w = ($urandom_range(0, 7) != 0);
      else                            w = 1'($urandom_range(0, 1));
      wd = $urandom();
      issue(ra, w, sz, wd, 0, 1'b0, 32'h0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
